// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared types and width helpers for the direct-mapped I-cache.
//             FSM state encoding, word/byte constants and functions that
//             derive the offset / index / tag field widths from the cache
//             geometry parameters.
//  Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = WORD_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word-offset field width inside a line.
    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index field width.
    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is everything above byte, offset and index fields.
    function automatic int calc_tag_w(input int lines, input int words_per_line);
        return ADDR_W - $clog2(WORD_BYTES) - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_tag_ram.sv
`default_nettype none
// ============================================================================
//  Module   : icache_tag_ram
//  Purpose  : Storage for the direct-mapped I-cache: per-line valid flops,
//             tag array and data array. Asynchronous read, synchronous write.
//             Only the valid bits are reset; tag/data contents are don't-care
//             until their line becomes valid.
//  Ports    : clk, rstN         - clock, async active-low reset
//             rd_idx_i/rd_off_i - lookup address; rd_valid_o/rd_tag_o/
//                                 rd_data_o return the addressed entry
//             wr_data_en_i      - write wr_data_i at {wr_idx_i, wr_off_i}
//             wr_tag_en_i       - write wr_tag_i at wr_idx_i
//             set_valid_i       - mark line wr_idx_i valid
//             clr_all_i         - invalidate every line (wins over set)
//  Revision : 1.0 - initial release
// ============================================================================
module icache_tag_ram
    import icache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFF_W          = calc_off_w(WORDS_PER_LINE),
    parameter int IDX_W          = calc_idx_w(LINES),
    parameter int TAG_W          = calc_tag_w(LINES, WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_data_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_tag_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              set_valid_i,
    input  logic              clr_all_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (set_valid_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_data_en_i) begin
            data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped read-only instruction cache for the IF stage.
//             Zero-latency combinational hit; on a miss a multi-beat line
//             refill is run against the instruction memory port.
//  Ports    : clk, rstN          - clock, async active-low reset
//             pc, flush          - fetch byte address, invalidate-all
//             hit, instr         - lookup result (instr=0 when hit=0)
//             memReq, memAddr    - refill beat request / word address
//             memData, memValid  - refill word return
//             hitCount,missCount - only with ICACHE_STATS_EN defined
//  Build    : `define ICACHE_STATS_EN adds saturating hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        hit,
    output logic [31:0] instr,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic [31:0] memData,
    input  logic        memValid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int OFF_W    = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W    = calc_idx_w(LINES);
    localparam int TAG_W    = calc_tag_w(LINES, WORDS_PER_LINE);
    localparam int BYTE_W   = $clog2(WORD_BYTES);
    localparam int LINE_LSB = BYTE_W + OFF_W;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;

    state_e                  state_q;
    logic [OFF_W-1:0]        beat_q;
    logic [31-LINE_LSB:0]    miss_line_q;   // {tag, idx} of the line being refilled
    logic                    mem_req_q;
    logic [31:0]             mem_addr_q;

    logic [OFF_W-1:0]        w_pc_off;
    logic [IDX_W-1:0]        w_pc_idx;
    logic [TAG_W-1:0]        w_pc_tag;
    logic [IDX_W-1:0]        w_miss_idx;
    logic [TAG_W-1:0]        w_miss_tag;
    logic                    w_rd_valid;
    logic [TAG_W-1:0]        w_rd_tag;
    logic [DATA_W-1:0]       w_rd_data;
    logic                    w_beat_accept;
    logic                    w_last_beat;
    logic                    w_start_miss;
    logic                    w_unused_pc;

    assign w_pc_off    = pc[LINE_LSB-1:BYTE_W];
    assign w_pc_idx    = pc[TAG_LSB-1:LINE_LSB];
    assign w_pc_tag    = pc[31:TAG_LSB];
    assign w_unused_pc = ^pc[BYTE_W-1:0];

    assign w_miss_idx  = miss_line_q[IDX_W-1:0];
    assign w_miss_tag  = miss_line_q[31-LINE_LSB:IDX_W];

    // Lookups are only trusted in IDLE: during a refill the target line may
    // still be marked valid while its data is being overwritten.
    assign hit   = w_rd_valid && (w_rd_tag == w_pc_tag) && (state_q == IDLE);
    assign instr = hit ? w_rd_data : 32'h0;

    // A flush abandons the refill, so the beat arriving with it is dropped.
    assign w_beat_accept = (state_q == FILL) && memValid && !flush;
    assign w_last_beat   = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
    assign w_start_miss  = (state_q == IDLE) && !hit && !flush;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            miss_line_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
        end else if (flush && (state_q != IDLE)) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            mem_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_start_miss) begin
                        miss_line_q <= pc[31:LINE_LSB];
                        mem_addr_q  <= {pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
                        beat_q      <= '0;
                        mem_req_q   <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (memValid) begin
                        if (w_last_beat) begin
                            mem_req_q <= 1'b0;
                            state_q   <= DONE;
                        end else begin
                            beat_q     <= beat_q + OFF_W'(1);
                            mem_addr_q <= mem_addr_q + 32'(WORD_BYTES);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign memReq  = mem_req_q;
    assign memAddr = mem_addr_q;

    icache_tag_ram #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .OFF_W          (OFF_W),
        .IDX_W          (IDX_W),
        .TAG_W          (TAG_W)
    ) u_tag_ram (
        .clk          (clk),
        .rstN         (rstN),
        .rd_idx_i     (w_pc_idx),
        .rd_off_i     (w_pc_off),
        .rd_valid_o   (w_rd_valid),
        .rd_tag_o     (w_rd_tag),
        .rd_data_o    (w_rd_data),
        .wr_data_en_i (w_beat_accept),
        .wr_idx_i     (w_miss_idx),
        .wr_off_i     (beat_q),
        .wr_data_i    (memData),
        .wr_tag_en_i  (w_beat_accept && w_last_beat),
        .wr_tag_i     (w_miss_tag),
        .set_valid_i  ((state_q == DONE) && !flush),
        .clr_all_i    (flush)
    );

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else if (flush) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (w_start_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Self-checking bench for icache_dm. A cycle table drives pc,
//             flush and memory-response enable and checks hit/instr/memReq/
//             memAddr; a queue holds the beat addresses each miss must issue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

    localparam int LINES = 64;
    localparam int WPL   = 4;

    logic        clk;
    logic        rstN;
    logic [31:0] pc;
    logic        flush;
    logic        hit;
    logic [31:0] instr;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        memValid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    icache_dm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .pc       (pc),
        .flush    (flush),
        .hit      (hit),
        .instr    (instr),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memData  (memData),
        .memValid (memValid)
`ifdef ICACHE_STATS_EN
        ,
        .hitCount (hitCount),
        .missCount(missCount)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mem_en;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        en;
        logic        push;
        logic        clr;
        logic        ehit;
        logic [31:0] einstr;
        logic        ereq;
        logic [31:0] eaddr;
    } row_t;

    row_t tbl[$];

    // Memory image: line 0x40 holds A0..A3, other addresses follow the ramp.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h40) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        for (int i = 0; i < WPL; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Drive this cycle's memory response, then advance to 1 time unit past
    // the next rising edge. memValid is also raised while memReq is low to
    // show that unrequested beats are ignored.
    task automatic step();
        if (mem_en) begin
            memValid = 1'b1;
            if (memReq) begin
                memData = mem_word(memAddr);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_beat: beat requested at %h, expected none", memAddr);
                end else begin
                    check("sb_beat_addr", memAddr, exp_q.pop_front());
                end
            end else begin
                memData = 32'hBAD0_0000;
            end
        end else begin
            memValid = 1'b0;
            memData  = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] p, input logic fl, input logic en, input logic push,
                       input logic clr, input logic eh, input logic [31:0] ei,
                       input logic er, input logic [31:0] ea);
        row_t r;
        r.pc = p; r.fl = fl; r.en = en; r.push = push; r.clr = clr;
        r.ehit = eh; r.einstr = ei; r.ereq = er; r.eaddr = ea;
        tbl.push_back(r);
    endtask

    initial begin
        //   pc            fl  en  push clr  hit instr         req addr
        // Cold miss on 0x40, memory stalls 3 cycles, then 4 back-to-back beats
        add(32'h0000_0040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_0040, 0, 0, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 0, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 0, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h44);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h48);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h4C);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         0, 32'h0);   // DONE
        add(32'h0000_0040, 0, 0, 0, 0, 1, 32'hA0,        0, 32'h0);
        add(32'h0000_0048, 0, 0, 0, 0, 1, 32'hA2,        0, 32'h0);
        add(32'h0000_004C, 0, 0, 0, 0, 1, 32'hA3,        0, 32'h0);
        add(32'h0000_0044, 0, 0, 0, 0, 1, 32'hA1,        0, 32'h0);
        // Same index, new tag: evicts line 0x40
        add(32'h0000_1040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h1040);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h1044);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h1048);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h104C);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         0, 32'h0);   // DONE
        add(32'h0000_104C, 0, 0, 0, 0, 1, 32'h4A3,       0, 32'h0);
        add(32'h0000_0040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);   // conflict miss
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h44);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h48);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h4C);
        add(32'h0000_0040, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_0040, 0, 0, 0, 0, 1, 32'hA0,        0, 32'h0);
        // Flush in IDLE, then a pc change after beat 1 of the refill
        add(32'h0000_0040, 1, 0, 0, 0, 1, 32'hA0,        0, 32'h0);
        add(32'h0000_0040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h44);
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h48);
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h4C);
        add(32'h0000_0080, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0);   // DONE
        add(32'h0000_0080, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);   // new miss
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h80);
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h84);
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h88);
        add(32'h0000_0080, 0, 1, 0, 0, 0, 32'h0,         1, 32'h8C);
        add(32'h0000_0080, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_0080, 0, 0, 0, 0, 1, 32'hB0,        0, 32'h0);
        add(32'h0000_0040, 0, 0, 0, 0, 1, 32'hA0,        0, 32'h0);
        // Flush during beat 2 of an evicting refill
        add(32'h0000_1040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h1040);
        add(32'h0000_1040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h1044);
        add(32'h0000_1040, 1, 1, 0, 1, 0, 32'h0,         1, 32'h1048);
        add(32'h0000_0040, 0, 0, 1, 0, 0, 32'h0,         0, 32'h0);   // memReq dropped, 0x40 misses
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h40);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h44);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h48);
        add(32'h0000_0040, 0, 1, 0, 0, 0, 32'h0,         1, 32'h4C);
        add(32'h0000_0040, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0);
        add(32'h0000_0040, 0, 0, 0, 0, 1, 32'hA0,        0, 32'h0);

        // Reset state
        rstN     = 1'b0;
        pc       = 32'h40;
        flush    = 1'b0;
        memValid = 1'b0;
        memData  = 32'h0;
        mem_en   = 1'b0;
        #12;
        check("rst_hit",     32'(hit),    32'h0);
        check("rst_instr",   instr,       32'h0);
        check("rst_memReq",  32'(memReq), 32'h0);
        check("rst_memAddr", memAddr,     32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hitCount",  hitCount,  32'h0);
        check("rst_missCount", missCount, 32'h0);
`endif
        @(posedge clk);
        #1;
        rstN = 1'b1;

        foreach (tbl[i]) begin
            pc     = tbl[i].pc;
            flush  = tbl[i].fl;
            mem_en = tbl[i].en;
            #1;
            check($sformatf("row%0d_hit", i),    32'(hit),    32'(tbl[i].ehit));
            check($sformatf("row%0d_instr", i),  instr,       tbl[i].einstr);
            check($sformatf("row%0d_memReq", i), 32'(memReq), 32'(tbl[i].ereq));
            if (tbl[i].ereq) check($sformatf("row%0d_memAddr", i), memAddr, tbl[i].eaddr);
            if (tbl[i].push) push_line(tbl[i].pc);
            step();
            if (tbl[i].clr) exp_q.delete();
        end
        flush = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
`ifdef ICACHE_STATS_EN
        check("stats_hitCount",  hitCount,  32'd1);
        check("stats_missCount", missCount, 32'd1);
`endif

        // Reset asserted in the middle of a refill
        pc     = 32'h1040;
        mem_en = 1'b0;
        push_line(pc);
        #1;
        check("mid_rst_premiss_hit", 32'(hit), 32'h0);
        step();
        mem_en = 1'b1;
        #1;
        check("mid_rst_fill_req", 32'(memReq), 32'h1);
        step();                          // beat 0 accepted, now at beat 1
        rstN = 1'b0;
        #1;
        check("mid_rst_memReq",  32'(memReq), 32'h0);
        check("mid_rst_hit",     32'(hit),    32'h0);
        check("mid_rst_memAddr", memAddr,     32'h0);
`ifdef ICACHE_STATS_EN
        check("mid_rst_hitCount",  hitCount,  32'h0);
        check("mid_rst_missCount", missCount, 32'h0);
`endif
        exp_q.delete();
        mem_en   = 1'b0;
        memValid = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        pc   = 32'h40;
        #1;
        check("post_rst_hit",    32'(hit),    32'h0);
        check("post_rst_instr",  instr,       32'h0);
        check("post_rst_memReq", 32'(memReq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache that answers the PC register's fetch address.
- Drives the `hit` signal that PCRegister consumes to stall (hit=0) or advance (hit=1).
- On a miss, runs a multi-beat line refill from the instruction memory port; the fetch retries until hit=1.
- Sits between PCRegister and the instruction memory in the IF stage.

Parameters:
LINES, 64, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
pc  input  32  fetch byte address from PCRegister (outPC); bits [1:0] ignored
flush  input  1  invalidate all lines
hit  output  1  instr valid for current pc; PCRegister holds when 0
instr  output  32  instruction word for pc; 0 when hit=0
memReq  output  1  refill beat request, held high through the refill
memAddr  output  32  word-aligned byte address of the requested beat
memData  input  32  refill word
memValid  input  1  memData valid this cycle; one word accepted per cycle

Behaviour:
- Address split (LSB first):
  - 2 byte bits.
  - OFF = log2(WORDS_PER_LINE) word-offset bits.
  - IDX = log2(LINES) index bits.
  - Remaining bits are the tag.
- Storage: valid bit per line (flops), tag array, data array; all arrays are flops or asynchronous-read.
- hit = valid[idx] & (tag[idx] == pc.tag) & (state == IDLE). Combinational from pc, so zero-cycle hit latency.
- instr = data[idx][off] when hit, else 32'h0.
- Reset (async, rstN=0) sets:
  - all valid bits to 0, state IDLE;
  - memReq=0, memAddr=0, beat counter 0;
  - hit=0 (no valid lines);
  - tag and data arrays are not reset.
- FSM states:
  - IDLE:
    - If hit=0 and flush=0, latch the line base (pc with the OFF and byte bits cleared) into missAddr.
    - Clear the beat counter and go to FILL.
  - FILL:
    - memReq=1, memAddr = missAddr + 4*beat.
    - On each cycle with memValid=1, write memData into data[missIdx][beat] and increment beat.
    - When the beat equal to WORDS_PER_LINE-1 is accepted, write the tag and go to DONE.
    - memValid while memReq=0 is ignored.
  - DONE (1 cycle):
    - Set valid[missIdx]=1, memReq=0, then return to IDLE.
    - hit rises in the IDLE cycle if pc still maps to the line.
- Miss latency: 1 (IDLE detect) + WORDS_PER_LINE accepted beats + 1 (DONE) cycles before hit=1, given back-to-back memValid.
- memAddr is held stable while memReq=1 and memValid=0.
- Refill always completes for the latched missAddr, even if pc changes mid-FILL. hit is then re-evaluated against the new pc in IDLE and may start another miss.
- Replacement: a miss to a valid line with a different tag overwrites it. valid stays 1 throughout, but hit is forced 0 outside IDLE, so stale data is never returned.
- flush:
  - In IDLE: all valid bits clear at the next edge, and no miss is started that cycle.
  - In FILL or DONE: aborts to IDLE; memReq=0 the next cycle, and no valid bit is set. Beats still in flight from memory are ignored.
- Reset mid-FILL: immediate abort. State, valids and memReq are as above.
- pc bit [31] and all other upper bits participate in the tag; address wrap has no special handling.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined:
  - Adds output hitCount[31:0]: increments every cycle hit=1.
  - Adds output missCount[31:0]: increments on each IDLE→FILL transition.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0 on rstN, and are cleared by flush.
- When undefined: the ports and counters are absent, with no other change.

Decomposition:
- Package icache_pkg holds:
  - FSM state enum: IDLE=2'd0, FILL=2'd1, DONE=2'd2;
  - derived-width localparam functions: OFF_W, IDX_W, TAG_W;
  - the WORD_BYTES=4 constant.
- One sub-module: icache_tag_ram, holding the valid, tag and data arrays with async read and sync write ports. The FSM lives in icache_dm.

Test Plan:
- Reset, pc=32'h0000_0040, memValid=0 → hit=0, memReq=1 from cycle 1, memAddr=32'h40. Hold memValid low 3 cycles → memAddr stays 32'h40.
- Miss pc=32'h40 with memData 32'hA0..A3 on 4 consecutive cycles → memAddr steps 40/44/48/4C, DONE, then hit=1. At pc=32'h48, instr=32'hA2 with no further memReq.
- After that fill, pc=32'h0000_1040 (same index, new tag) → hit=0 and refill from 32'h1040. Then pc=32'h40 misses again (conflict eviction).
- Mid-FILL pc change from 32'h40 to 32'h80 after beat 1 → fill of 32'h40 completes, then a new miss issues memAddr=32'h80.
- flush pulse during FILL at beat 2 → memReq=0 next cycle. pc=32'h40 misses again, and valid was never set.
- rstN=0 during FILL beat 1 → memReq=0, hit=0 immediately. After release, a previously filled line misses. With ICACHE_STATS_EN, counters read 0.
